// File: rtl/tracer_pkg.sv
// Shared types and helpers for the memory write tracer: frame layout,
// transmitter states and the captured write record.
package tracer_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  // Frame is sent sync byte first, then address and data most significant byte first
  function automatic logic [7:0] frame_byte(input trace_entry_t entry, input logic [2:0] idx);
    case (idx)
      3'd0:    frame_byte = SYNC_BYTE;
      3'd1:    frame_byte = entry.addr[15:8];
      3'd2:    frame_byte = entry.addr[7:0];
      3'd3:    frame_byte = entry.data[31:24];
      3'd4:    frame_byte = entry.data[23:16];
      3'd5:    frame_byte = entry.data[15:8];
      default: frame_byte = entry.data[7:0];
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding captured writes; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 48
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_write_tracer.sv
// Snoops CPU data-memory writes into a FIFO and streams each one out as a
// 7-byte 8N1 UART frame for on-board observation of stores.
module mem_write_tracer #(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_KEEP    = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [31:0]            data_mem_address_i,
  input  logic [31:0]            data_mem_in_data_i,
  input  logic                   data_mem_WE_i,
  output logic                   uart_tx_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] fifo_count_o,
  output logic                   overflow_o,
  output logic [15:0]            drop_count_o
);

  import tracer_pkg::*;

  localparam int              TW         = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   BIT_RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [15:0]     ADDR_MASK  = 16'((32'd1 << ADDR_KEEP) - 32'd1);

  tx_state_t    state;
  trace_entry_t push_entry;
  trace_entry_t head_entry;
  trace_entry_t frame;
  logic [2:0]   byte_idx;
  logic [2:0]   bit_idx;
  logic [7:0]   shift;
  logic [TW-1:0] timer;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic         drop;
  logic         unused_addr_hi;

  assign push_entry.addr = data_mem_address_i[15:0] & ADDR_MASK;
  assign push_entry.data = data_mem_in_data_i;
  assign unused_addr_hi  = ^data_mem_address_i[31:16];

  assign fifo_pop = (state == IDLE) && !fifo_empty;
  assign drop     = data_mem_WE_i && fifo_full && !fifo_pop;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(trace_entry_t))
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (data_mem_WE_i),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_o),
    .head      (head_entry)
  );

  // Dropped writes are remembered until reset; the counter sticks at its maximum
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overflow_o   <= 1'b0;
      drop_count_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 1'b1;
    end
  end

  // Each byte costs one LOAD cycle plus ten bit periods (start, 8 data, stop)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      uart_tx_o <= 1'b1;
      busy_o    <= 1'b0;
      frame     <= '0;
      byte_idx  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx_o <= 1'b1;
          if (!fifo_empty) begin
            frame    <= head_entry;
            byte_idx <= '0;
            busy_o   <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          shift     <= frame_byte(frame, byte_idx);
          uart_tx_o <= 1'b0;
          timer     <= BIT_RELOAD;
          state     <= START;
        end
        START: begin
          if (timer == '0) begin
            uart_tx_o <= shift[0];
            shift     <= {1'b0, shift[7:1]};
            bit_idx   <= '0;
            timer     <= BIT_RELOAD;
            state     <= DATA;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        DATA: begin
          if (timer == '0) begin
            timer <= BIT_RELOAD;
            if (bit_idx == 3'd7) begin
              uart_tx_o <= 1'b1;
              state     <= STOP;
            end else begin
              uart_tx_o <= shift[0];
              shift     <= {1'b0, shift[7:1]};
              bit_idx   <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        STOP: begin
          if (timer == '0) begin
            if (byte_idx < 3'(FRAME_BYTES - 1)) begin
              byte_idx <= byte_idx + 1'b1;
              state    <= LOAD;
            end else begin
              busy_o <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          uart_tx_o <= 1'b1;
          busy_o    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_write_tracer.md
Name: mem_write_tracer

Overview:
- Snoops the CPU data-memory write port, the same CPU-to-Ram signals the Ram consumes, in parallel with the Ram.
- Each write's (address, data) pair is captured into a FIFO.
- Captured writes are drained as fixed 7-byte frames over an 8N1 UART transmit line.
- Lets store results be observed on the FPGA board without the simulator's write display.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
CLKS_PER_BIT, 434, CLK cycles per UART bit (>=2)
ADDR_KEEP, 16, low address bits captured (<=16; upper bits of frame field zero-filled)

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous active-high reset
data_mem_address_i  input  32  CPU data-memory address
data_mem_in_data_i  input  32  CPU store data
data_mem_WE_i  input  1  CPU data-memory write enable
uart_tx_o  output  1  serial output, idle high
busy_o  output  1  high while a frame is being sent
fifo_count_o  output  $clog2(DEPTH)+1  current FIFO occupancy
overflow_o  output  1  sticky: a write was dropped
drop_count_o  output  16  saturating count of dropped writes

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - uart_tx_o=1, busy_o=0, fifo_count_o=0, overflow_o=0, drop_count_o=0.
  - FIFO pointers 0; FSM in IDLE.
- Capture:
  - On each rising CLK with data_mem_WE_i=1, push {address[ADDR_KEEP-1:0] zero-extended to 16, data} (48 bits).
  - Back-to-back writes are captured every cycle.
- Full:
  - If FIFO is full and no pop occurs that edge, the write is dropped, overflow_o is set, and drop_count_o increments (saturates at 0xFFFF).
  - A push and a pop on the same edge with FIFO full both succeed.
  - Occupancy is unchanged when push and pop coincide.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop the head into the 48-bit frame register, byte index=0, go to LOAD.
  - An entry pushed at edge N is popped at edge N+1 at the earliest.
  - LOAD: select frame byte[index] into the shift register, go to START.
  - START: uart_tx_o=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles.
  - STOP: uart_tx_o=1 for CLKS_PER_BIT cycles.
  - After STOP, if index<6: index+1 and go to LOAD. Otherwise go to IDLE.
  - LOAD is one cycle with uart_tx_o held 1.
  - Frame duration is 7*(10*CLKS_PER_BIT+1) cycles.
- Frame byte order: 0xA5, addr[15:8], addr[7:0], data[31:24], data[23:16], data[15:8], data[7:0].
- busy_o is high in every state other than IDLE.
- Bit timer is a down-counter reloaded to CLKS_PER_BIT-1 on each bit entry; no fractional baud.
- Reset mid-frame: uart_tx_o returns to 1 immediately (asynchronous), the frame is abandoned, FIFO contents are discarded, and overflow/drop are cleared.
- overflow_o and drop_count_o are cleared only by RST.

Decomposition:
- Package tracer_pkg:
  - SYNC_BYTE=8'hA5, FRAME_BYTES=7.
  - State enum tx_state_t {IDLE, LOAD, START, DATA, STOP}.
  - Typedef trace_entry_t (packed struct addr[15:0], data[31:0]).
- Sub-module trace_fifo:
  - Parameterised DEPTH and width.
  - Ports: push, pop, full, empty, count, head data.
  - Handles simultaneous push/pop when full.
  - The top level holds the FSM, bit timer and drop logic.

Test Plan:
- CLKS_PER_BIT=4. One write, addr 0x00000010, data 0x12345678:
  - UART decoder receives A5 00 10 12 34 56 78.
  - busy_o is high for 7*41=287 cycles, then low.
- Address 0xFFFF1234, data 0xDEADBEEF, ADDR_KEEP=10:
  - Receive A5 02 34 DE AD BE EF (address masked to 10 bits).
- DEPTH=4, six writes on consecutive edges starting with FIFO empty:
  - Five frames are received in order.
  - overflow_o=1, drop_count_o=1 (sixth write dropped).
  - fifo_count_o peaks at 4.
- DEPTH=4, FIFO full, write on the same edge the FSM pops:
  - Write accepted, fifo_count_o stays 4, overflow_o stays 0.
- Assert RST mid-DATA of byte 3:
  - uart_tx_o=1 before the next edge, busy_o=0, fifo_count_o=0.
  - After release, a new write yields a complete clean frame.
- 70000 writes with FSM stalled full (DEPTH=2, CLKS_PER_BIT large):
  - drop_count_o saturates at 0xFFFF and does not wrap.
